// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register.
// This stage resolves the branch/jump redirect for the PC mux. It also accesses
// a word-addressed data memory with a latency of MEM_LAT extra cycles, and stalls
// the upstream stages while an access is in flight. On the completion edge it
// registers the WB control, the load data, the ALU result and the destination
// register toward the write-back mux.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag and squash misaligned
// word accesses. When it is undefined, alu_in[1:0] is ignored.
module mem_wb_stage #(
  parameter int unsigned ADDR_W  = 8,  // word-address width; depth = 2**ADDR_W words
  parameter int unsigned MEM_LAT = 2   // stall cycles per load/store (0..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,         // {RegWrite, MemToReg}
  input  logic        branch_in,
  input  logic        memr_in,
  input  logic        memw_in,
  input  logic        zero_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] br_target_in,
  input  logic        jump_in,
  input  logic [31:0] jtarget_in,
  output logic        pcsrc,
  output logic [31:0] pc_target,
  output logic        stall,
  output logic [1:0]  wb_out,
  output logic [31:0] rdata_out,
  output logic [31:0] alu_out,
  output logic [4:0]  rd_out,
  output logic        misalign_out
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam bit          HasLat  = (MEM_LAT > 0);
  // Counter preload on entry to busy; the stall lasts CntInit+1 cycles.
  localparam logic [3:0]  CntInit = HasLat ? 4'(MEM_LAT - 1) : 4'd0;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [1:0]  wb_q, wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        mis_q, mis_d;

  logic [31:0] mem_q [Depth];

  logic [ADDR_W-1:0] addr;
  logic              acc;
  logic              misalign;
  logic              acc_ok;
  logic              is_load;
  logic              complete;
  logic              mem_we;
  logic [31:0]       rdata;
  logic              unused_alu;

  // Byte address to word index. Bits above the memory wrap silently.
  assign addr = alu_in[ADDR_W+1:2];
  assign acc  = memr_in | memw_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign   = acc & (alu_in[1:0] != 2'b00);
  assign unused_alu = ^alu_in[31:ADDR_W+2];
`else
  assign misalign   = 1'b0;
  assign unused_alu = ^{alu_in[31:ADDR_W+2], alu_in[1:0]};
`endif

  // A misaligned access is squashed, so it never occupies the memory.
  assign acc_ok  = acc & ~misalign;
  // Load and store together is treated as a store.
  assign is_load = memr_in & ~memw_in;
  assign rdata   = is_load ? mem_q[addr] : 32'd0;

  // Access FSM: decides stall and completion for the instruction in the stage.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc_ok && HasLat) begin
          stall   = 1'b1;
          cnt_d   = CntInit;
          state_d = StBusy;
        end else begin
          complete = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The store commits only on the completion edge, so each store is written
  // exactly once. Reset during busy aborts the store.
  assign mem_we = complete & acc_ok & memw_in & ~rst;

  // Redirect is held off while stalled so the PC stays frozen with the pipe.
  always_comb begin
    pcsrc     = ((branch_in & zero_in) | jump_in) & ~stall;
    pc_target = jump_in ? jtarget_in : br_target_in;
  end

  // MEM/WB next state: the completing instruction, or a bubble on stalled edges.
  always_comb begin
    wb_d    = 2'b00;
    rdata_d = 32'd0;
    alu_d   = 32'd0;
    rd_d    = 5'd0;
    mis_d   = 1'b0;
    if (complete) begin
      alu_d = alu_in;
      rd_d  = rd_in;
      if (misalign) begin
        // Squashed access: no register write and no load data.
        mis_d = 1'b1;
      end else begin
        wb_d    = wb_in;
        rdata_d = rdata;
      end
    end
  end

  // FSM state, latency counter and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wb_q    <= 2'b00;
      rdata_q <= 32'd0;
      alu_q   <= 32'd0;
      rd_q    <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
    end
  end

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr] <= wdata_in;
    end
  end

  assign wb_out       = wb_q;
  assign rdata_out    = rdata_q;
  assign alu_out      = alu_q;
  assign rd_out       = rd_q;
  assign misalign_out = mis_q;

endmodule
